// File: rtl/mem_access_unit.sv
// Load/store front-end for a 256x16 word memory with one-cycle registered read.
// Accepts one LW/SW/LB/SB request at a time over valid/ready and returns a
// single-cycle response. Byte stores are performed as read-modify-write since
// the memory only writes whole 16-bit words. Byte lanes are big-endian:
// lane 0 is [15:8], lane 1 is [7:0].
module mem_access_unit #(
  parameter int ADDR_W          = 8,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata
);

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LB = 2'b10;
  localparam logic [1:0] OP_SB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    CAP  = 2'b10,
    WR   = 2'b11
  } state_t;

  state_t     state;
  logic [1:0] op_reg;
  logic       lane_reg;
  logic [7:0] wbyte_reg;

  logic accept;
  logic misalign;

  // Handshake and memory strobes decode straight from the state register so
  // they are glitch-free and each strobe lasts exactly one state.
  assign req_ready = (state == IDLE);
  assign mem_read  = (state == RD);
  assign mem_write = (state == WR);
  assign accept    = req_valid && req_ready;

  // Word ops (op[1]==0) at an odd address are only rejected when enabled.
  assign misalign  = ERR_ON_MISALIGN && !req_op[1] && req_addr[0];

  // Request sequencer: accept, read, capture, (merge and) write, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_reg     <= OP_LW;
      lane_reg   <= 1'b0;
      wbyte_reg  <= 8'h00;
      resp_valid <= 1'b0;
      resp_rdata <= 16'h0000;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 16'h0000;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_reg    <= req_op;
            lane_reg  <= req_addr[0];
            wbyte_reg <= req_wdata[7:0];
            if (misalign) begin
              // Rejected without touching memory; answer next cycle.
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 16'h0000;
            end else begin
              mem_addr <= {req_addr[ADDR_W-1:1], 1'b0};
              if (req_op == OP_SW) begin
                mem_wdata <= req_wdata;
                state     <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          case (op_reg)
            OP_LW: begin
              resp_rdata <= mem_rdata;
              resp_err   <= 1'b0;
              resp_valid <= 1'b1;
              state      <= IDLE;
            end
            OP_LB: begin
              resp_rdata <= lane_reg ? {8'h00, mem_rdata[7:0]}
                                     : {8'h00, mem_rdata[15:8]};
              resp_err   <= 1'b0;
              resp_valid <= 1'b1;
              state      <= IDLE;
            end
            OP_SB: begin
              // Merge the new byte into the word just read, then write back.
              mem_wdata <= lane_reg ? {mem_rdata[15:8], wbyte_reg}
                                    : {wbyte_reg, mem_rdata[7:0]};
              state     <= WR;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_rdata <= 16'h0000;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. Two instances run in lockstep on the same
// request stream: inst0 rejects misaligned word ops, inst1 ignores addr[0].
// Each has its own behavioural memory; a word-array reference model predicts
// responses, latencies, strobes and written data.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_err;
  logic [1:0]  mem_read;
  logic [1:0]  mem_write;
  logic [15:0] resp_rdata [2];
  logic [7:0]  mem_addr   [2];
  logic [15:0] mem_wdata  [2];
  logic [15:0] mem_rdata  [2];
  logic        init_mem;

  logic [15:0] mem       [2][256];
  logic [15:0] model_mem [2][128];

  int checks;
  int passes;
  logic [15:0] last_rdata [2];
  logic        last_err   [2];

  mem_access_unit #(.ADDR_W(8), .ERR_ON_MISALIGN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_access_unit #(.ADDR_W(8), .ERR_ON_MISALIGN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 256x16 memories with one-cycle registered read.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mem
    always @(posedge clk) begin
      if (init_mem) begin
        for (int k = 0; k < 256; k++) mem[gi][k] <= 16'h0000;
        mem[gi][0] <= 16'h2BCD;
        mem[gi][4] <= 16'h1234;
        mem[gi][6] <= 16'hDEAD;
        mem[gi][8] <= 16'hBEEF;
      end else begin
        if (mem_read[gi])  mem_rdata[gi] <= mem[gi][mem_addr[gi]];
        if (mem_write[gi]) mem[gi][mem_addr[gi]] <= mem_wdata[gi];
      end
    end
  end

  // Reference model: what a request should do, from the op's definition.
  task automatic model_exec(input int i, input logic [1:0] op, input logic [7:0] addr,
                            input logic [15:0] wd, output int e_lat, output logic [15:0] e_rdata,
                            output logic e_err, output int e_nrd, output int e_nwr,
                            output logic [7:0] e_addr, output logic [15:0] e_wdata);
    int w;
    logic [15:0] word;
    w = addr / 2;
    word = model_mem[i][w];
    e_addr = 8'(w * 2);
    e_rdata = 16'h0000;
    e_err = 1'b0;
    e_wdata = 16'h0000;
    if (i == 0 && op <= 2'd1 && (addr % 2) == 1) begin
      e_lat = 1; e_err = 1'b1; e_nrd = 0; e_nwr = 0;
    end else if (op == 2'd0) begin
      e_lat = 3; e_rdata = word; e_nrd = 1; e_nwr = 0;
    end else if (op == 2'd1) begin
      e_lat = 2; e_nrd = 0; e_nwr = 1; e_wdata = wd;
      model_mem[i][w] = wd;
    end else if (op == 2'd2) begin
      e_lat = 3; e_nrd = 1; e_nwr = 0;
      e_rdata = (addr % 2 == 1) ? (word % 256) : (word / 256);
    end else begin
      e_lat = 4; e_nrd = 1; e_nwr = 1;
      if (addr % 2 == 1) e_wdata = (word / 256) * 256 + (wd % 256);
      else               e_wdata = (wd % 256) * 256 + (word % 256);
      model_mem[i][w] = e_wdata;
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 128; k++) model_mem[i][k] = 16'h0000;
      model_mem[i][0] = 16'h2BCD;
      model_mem[i][2] = 16'h1234;
      model_mem[i][3] = 16'hDEAD;
      model_mem[i][4] = 16'hBEEF;
    end
  endtask

  // One request through both instances, compared against the model.
  task automatic run_req(input string name, input logic [1:0] op, input logic [7:0] addr,
                         input logic [15:0] wd);
    int guard;
    int lat [2]; int nrd [2]; int nwr [2]; int rdk [2]; int wrk [2];
    logic [7:0] raddr [2]; logic [7:0] waddr [2]; logic [15:0] wdat [2];
    logic [15:0] rdat [2]; logic er [2]; logic bad [2];
    int e_lat; logic [15:0] e_rdata; logic e_err; int e_nrd; int e_nwr;
    logic [7:0] e_addr; logic [15:0] e_wdata;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    guard = 0;
    while (req_ready !== 2'b11 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 20) $display("FAIL %s ready_timeout: got ready=%b required 11", name, req_ready);
    else passes++;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      lat[i] = 0; nrd[i] = 0; nwr[i] = 0; rdk[i] = 0; wrk[i] = 0; raddr[i] = 0;
      waddr[i] = 0; wdat[i] = 0; rdat[i] = 0; er[i] = 0; bad[i] = 0;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (lat[i] == 0) begin
          if (mem_read[i] === 1'b1)  begin nrd[i]++; rdk[i] = k; raddr[i] = mem_addr[i]; end
          if (mem_write[i] === 1'b1) begin nwr[i]++; wrk[i] = k; waddr[i] = mem_addr[i]; wdat[i] = mem_wdata[i]; end
          if (mem_read[i] === 1'b1 && mem_write[i] === 1'b1) bad[i] = 1'b1;
          if ((mem_read[i] | mem_write[i]) === 1'b1 && mem_addr[i][0] !== 1'b0) bad[i] = 1'b1;
          if (resp_valid[i] === 1'b1) begin lat[i] = k; rdat[i] = resp_rdata[i]; er[i] = resp_err[i]; end
        end
      end
      if (lat[0] != 0 && lat[1] != 0) break;
    end
    for (int i = 0; i < 2; i++) begin
      model_exec(i, op, addr, wd, e_lat, e_rdata, e_err, e_nrd, e_nwr, e_addr, e_wdata);
      checks++;
      if (lat[i] != e_lat) $display("FAIL %s inst%0d latency: got %0d required %0d", name, i, lat[i], e_lat);
      else passes++;
      checks++;
      if (rdat[i] !== e_rdata) $display("FAIL %s inst%0d rdata: got %h required %h", name, i, rdat[i], e_rdata);
      else passes++;
      checks++;
      if (er[i] !== e_err) $display("FAIL %s inst%0d err: got %b required %b", name, i, er[i], e_err);
      else passes++;
      checks++;
      if (nrd[i] != e_nrd || nwr[i] != e_nwr)
        $display("FAIL %s inst%0d strobes: got rd=%0d wr=%0d required rd=%0d wr=%0d", name, i, nrd[i], nwr[i], e_nrd, e_nwr);
      else passes++;
      checks++;
      if (bad[i] !== 1'b0) $display("FAIL %s inst%0d strobe_overlap_or_odd_addr: got 1 required 0", name, i);
      else passes++;
      if (e_nrd > 0) begin
        checks++;
        if (raddr[i] !== e_addr || rdk[i] != 1)
          $display("FAIL %s inst%0d read: got addr=%h cycle=%0d required addr=%h cycle=1", name, i, raddr[i], rdk[i], e_addr);
        else passes++;
      end
      if (e_nwr > 0) begin
        checks++;
        if (waddr[i] !== e_addr || wdat[i] !== e_wdata || wrk[i] != e_lat - 1)
          $display("FAIL %s inst%0d write: got addr=%h data=%h cycle=%0d required addr=%h data=%h cycle=%0d",
                   name, i, waddr[i], wdat[i], wrk[i], e_addr, e_wdata, e_lat - 1);
        else passes++;
      end
      last_rdata[i] = rdat[i];
      last_err[i] = er[i];
    end
    $display("txn %s op=%0d addr=%h wdata=%h -> inst0 %h/%b lat %0d, inst1 %h/%b lat %0d",
             name, op, addr, wd, rdat[0], er[0], lat[0], rdat[1], er[1], lat[1]);
  endtask

  task automatic test_reset();
    reset = 1'b1; init_mem = 1'b1; req_valid = 1'b0;
    req_op = 2'b00; req_addr = 8'h00; req_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (req_ready[i] !== 1'b1 || resp_valid[i] !== 1'b0 || resp_err[i] !== 1'b0 || resp_rdata[i] !== 16'h0)
        $display("FAIL reset_resp inst%0d: got ready=%b valid=%b err=%b rdata=%h required 1 0 0 0000",
                 i, req_ready[i], resp_valid[i], resp_err[i], resp_rdata[i]);
      else passes++;
      checks++;
      if (mem_read[i] !== 1'b0 || mem_write[i] !== 1'b0 || mem_addr[i] !== 8'h00 || mem_wdata[i] !== 16'h0)
        $display("FAIL reset_mem inst%0d: got rd=%b wr=%b addr=%h wdata=%h required 0 0 00 0000",
                 i, mem_read[i], mem_write[i], mem_addr[i], mem_wdata[i]);
      else passes++;
    end
    reset = 1'b0; init_mem = 1'b0;
    model_init();
    $display("txn reset done");
  endtask

  task automatic test_loads();
    run_req("lw06", 2'b00, 8'h06, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (last_rdata[i] !== 16'hDEAD) $display("FAIL lw06_const inst%0d: got %h required dead", i, last_rdata[i]);
      else passes++;
    end
    run_req("lb04", 2'b10, 8'h04, 16'h0000);
    checks++;
    if (last_rdata[0] !== 16'h0012) $display("FAIL lb04_const: got %h required 0012", last_rdata[0]);
    else passes++;
    run_req("lb05", 2'b10, 8'h05, 16'h0000);
    checks++;
    if (last_rdata[0] !== 16'h0034) $display("FAIL lb05_const: got %h required 0034", last_rdata[0]);
    else passes++;
    run_req("lb01", 2'b10, 8'h01, 16'h0000);
    checks++;
    if (last_rdata[1] !== 16'h00CD) $display("FAIL lb01_const: got %h required 00cd", last_rdata[1]);
    else passes++;
  endtask

  task automatic test_byte_store();
    run_req("sb09", 2'b11, 8'h09, 16'h0077);
    run_req("lw08", 2'b00, 8'h08, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (last_rdata[i] !== 16'hBE77) $display("FAIL sb09_readback inst%0d: got %h required be77", i, last_rdata[i]);
      else passes++;
    end
  endtask

  task automatic test_misalign();
    run_req("sw03", 2'b01, 8'h03, 16'hAAAA);
    checks++;
    if (last_err[0] !== 1'b1 || last_err[1] !== 1'b0)
      $display("FAIL sw03_err: got %b%b required 10", last_err[0], last_err[1]);
    else passes++;
    run_req("lw02", 2'b00, 8'h02, 16'h0000);
    checks++;
    if (last_rdata[0] !== 16'h0000 || last_rdata[1] !== 16'hAAAA)
      $display("FAIL lw02_after_sw03: got %h %h required 0000 aaaa", last_rdata[0], last_rdata[1]);
    else passes++;
    run_req("lw07", 2'b00, 8'h07, 16'h0000);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w1;
    int k;
    w1 = 16'($urandom);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_addr = 8'h10; req_wdata = w1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) $display("FAIL b2b_busy_ready: got %b required 00", req_ready);
    else passes++;
    req_op = 2'b00;
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b11 || req_ready !== 2'b11)
      $display("FAIL b2b_overlap: got valid=%b ready=%b required 11 11", resp_valid, req_ready);
    else passes++;
    for (int i = 0; i < 2; i++) model_mem[i][8] = w1;
    @(posedge clk);
    k = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
      if (resp_valid === 2'b11) begin k = n; break; end
    end
    checks++;
    if (k != 3) $display("FAIL b2b_lw_latency: got %0d required 3", k);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_rdata[i] !== model_mem[i][8])
        $display("FAIL b2b_lw_data inst%0d: got %h required %h", i, resp_rdata[i], model_mem[i][8]);
      else passes++;
    end
    $display("txn b2b sw/lw 10 wdata=%h -> %h %h", w1, resp_rdata[0], resp_rdata[1]);
  endtask

  task automatic test_reset_mid_sb();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_addr = 8'h05; req_wdata = 16'h0099;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_read !== 2'b11) $display("FAIL rst_sb_read: got %b required 11", mem_read);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (mem_write !== 2'b00 || resp_valid !== 2'b00 || req_ready !== 2'b11)
        $display("FAIL rst_sb_quiet cycle%0d: got wr=%b valid=%b ready=%b required 00 00 11",
                 n, mem_write, resp_valid, req_ready);
      else passes++;
      @(negedge clk);
    end
    $display("txn sb05 aborted by reset");
    run_req("lw04_after_rst", 2'b00, 8'h04, 16'h0000);
    checks++;
    if (last_rdata[0] !== 16'h1234) $display("FAIL rst_sb_unchanged: got %h required 1234", last_rdata[0]);
    else passes++;
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] addr;
    logic [15:0] wd;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      addr = 8'($urandom_range(0, 31));
      wd = 16'($urandom);
      run_req("rand", op, addr, wd);
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_loads();
    test_byte_store();
    test_misalign();
    test_back_to_back();
    test_reset_mid_sb();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
